// File: rtl/exe_mem_reg.sv
// EXE/MEM pipeline register with a wait-state sequencer for a multi-cycle data memory.
// Loads/stores are held for MEM_WAIT extra cycles while upstream stages are frozen.
module exe_mem_reg #(
  parameter int N        = 32,
  parameter int MEM_WAIT = 2,
  parameter int STALL_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               validIn,
  input  logic               flushIn,
  input  logic               WB_ENIn,
  input  logic               MEM_R_ENIn,
  input  logic               MEM_W_ENIn,
  input  logic [N-1:0]       ALU_ResIn,
  input  logic [N-1:0]       Value_RmIn,
  input  logic [3:0]         DestIn,
  output logic               validOut,
  output logic               WB_ENOut,
  output logic               MEM_R_ENOut,
  output logic               MEM_W_ENOut,
  output logic [N-1:0]       ALU_ResOut,
  output logic [N-1:0]       Value_RmOut,
  output logic [3:0]         DestOut,
  output logic               freezeOut,
  output logic [STALL_W-1:0] stallCntOut
);

  localparam int CNT_W = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(MEM_WAIT);

  logic               r_valid;
  logic               r_wb_en;
  logic               r_mem_r_en;
  logic               r_mem_w_en;
  logic [N-1:0]       r_alu_res;
  logic [N-1:0]       r_value_rm;
  logic [3:0]         r_dest;
  logic [CNT_W-1:0]   r_cnt;
  logic [STALL_W-1:0] r_stall_cnt;

  logic w_run;
  logic w_cap_valid;
  logic w_cap_mem;
  logic w_stall_sat;

  assign w_run       = (r_cnt == '0);
  assign w_cap_valid = validIn & ~flushIn;
  assign w_cap_mem   = w_cap_valid & (MEM_R_ENIn | MEM_W_ENIn);
  assign w_stall_sat = &r_stall_cnt;

  // Capture in RUN; in HOLD the payload is frozen and only the wait counter moves.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid    <= 1'b0;
      r_wb_en    <= 1'b0;
      r_mem_r_en <= 1'b0;
      r_mem_w_en <= 1'b0;
      r_alu_res  <= '0;
      r_value_rm <= '0;
      r_dest     <= '0;
      r_cnt      <= '0;
    end else if (w_run) begin
      r_valid    <= w_cap_valid;
      r_wb_en    <= w_cap_valid & WB_ENIn;
      r_mem_r_en <= w_cap_valid & MEM_R_ENIn;
      r_mem_w_en <= w_cap_valid & MEM_W_ENIn;
      r_alu_res  <= ALU_ResIn;
      r_value_rm <= Value_RmIn;
      r_dest     <= DestIn;
      r_cnt      <= w_cap_mem ? WAIT_LOAD : '0;
    end else begin
      r_cnt      <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (!w_run && !w_stall_sat) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  // Write-back is only exposed in the last cycle of an access so MEM/WB commits once.
  assign validOut    = r_valid;
  assign WB_ENOut    = r_wb_en & w_run;
  assign MEM_R_ENOut = r_mem_r_en;
  assign MEM_W_ENOut = r_mem_w_en;
  assign ALU_ResOut  = r_alu_res;
  assign Value_RmOut = r_value_rm;
  assign DestOut     = r_dest;
  assign freezeOut   = ~w_run;
  assign stallCntOut = r_stall_cnt;

endmodule

// File: tb/tb_exe_mem_reg.sv
// Bench for exe_mem_reg: table-driven cycle vectors through a scoreboard queue,
// plus reset, reset-mid-hold and stall-counter saturation sequences.
module tb_exe_mem_reg;

  typedef struct {
    logic        v, f, wb, r, w;
    logic [31:0] alu, rm;
    logic [3:0]  d;
    logic        ev, ewb, er, ew;
    logic [31:0] ealu, erm;
    logic [3:0]  ed;
    logic        efz;
    logic [15:0] esc;
    logic        cd;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        validIn, flushIn, WB_ENIn, MEM_R_ENIn, MEM_W_ENIn;
  logic [31:0] ALU_ResIn, Value_RmIn;
  logic [3:0]  DestIn;

  logic        m_v, m_wb, m_r, m_w, m_fz;
  logic [31:0] m_alu, m_rm;
  logic [3:0]  m_d;
  logic [15:0] m_sc;

  logic        z_v, z_wb, z_r, z_w, z_fz;
  logic [31:0] z_alu, z_rm;
  logic [3:0]  z_d;
  logic [15:0] z_sc;

  logic        s_v, s_wb, s_r, s_w, s_fz;
  logic [31:0] s_alu, s_rm;
  logic [3:0]  s_d;
  logic [7:0]  s_sc;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs[21];
  vec_t q_main[$];
  vec_t q_z0[$];

  always #5 clk = ~clk;

  exe_mem_reg #(.N(32), .MEM_WAIT(2), .STALL_W(16)) dut (
    .clk(clk), .rst(rst), .validIn(validIn), .flushIn(flushIn), .WB_ENIn(WB_ENIn),
    .MEM_R_ENIn(MEM_R_ENIn), .MEM_W_ENIn(MEM_W_ENIn), .ALU_ResIn(ALU_ResIn),
    .Value_RmIn(Value_RmIn), .DestIn(DestIn), .validOut(m_v), .WB_ENOut(m_wb),
    .MEM_R_ENOut(m_r), .MEM_W_ENOut(m_w), .ALU_ResOut(m_alu), .Value_RmOut(m_rm),
    .DestOut(m_d), .freezeOut(m_fz), .stallCntOut(m_sc)
  );

  exe_mem_reg #(.N(32), .MEM_WAIT(0), .STALL_W(16)) dut_z0 (
    .clk(clk), .rst(rst), .validIn(validIn), .flushIn(flushIn), .WB_ENIn(WB_ENIn),
    .MEM_R_ENIn(MEM_R_ENIn), .MEM_W_ENIn(MEM_W_ENIn), .ALU_ResIn(ALU_ResIn),
    .Value_RmIn(Value_RmIn), .DestIn(DestIn), .validOut(z_v), .WB_ENOut(z_wb),
    .MEM_R_ENOut(z_r), .MEM_W_ENOut(z_w), .ALU_ResOut(z_alu), .Value_RmOut(z_rm),
    .DestOut(z_d), .freezeOut(z_fz), .stallCntOut(z_sc)
  );

  exe_mem_reg #(.N(32), .MEM_WAIT(3), .STALL_W(8)) dut_sat (
    .clk(clk), .rst(rst), .validIn(validIn), .flushIn(flushIn), .WB_ENIn(WB_ENIn),
    .MEM_R_ENIn(MEM_R_ENIn), .MEM_W_ENIn(MEM_W_ENIn), .ALU_ResIn(ALU_ResIn),
    .Value_RmIn(Value_RmIn), .DestIn(DestIn), .validOut(s_v), .WB_ENOut(s_wb),
    .MEM_R_ENOut(s_r), .MEM_W_ENOut(s_w), .ALU_ResOut(s_alu), .Value_RmOut(s_rm),
    .DestOut(s_d), .freezeOut(s_fz), .stallCntOut(s_sc)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, f, wb, r, w, input logic [31:0] alu, rm,
                              input logic [3:0] d, input logic ev, ewb, er, ew,
                              input logic [31:0] ealu, erm, input logic [3:0] ed,
                              input logic efz, input logic [15:0] esc, input logic cd);
    vec_t t;
    t.v = v; t.f = f; t.wb = wb; t.r = r; t.w = w; t.alu = alu; t.rm = rm; t.d = d;
    t.ev = ev; t.ewb = ewb; t.er = er; t.ew = ew; t.ealu = ealu; t.erm = erm; t.ed = ed;
    t.efz = efz; t.esc = esc; t.cd = cd;
    return t;
  endfunction

  // Reference for a zero-wait instance: a plain flushable register.
  function automatic vec_t model_z0(input vec_t in);
    vec_t t;
    t = in;
    t.ev   = in.v & ~in.f;
    t.ewb  = t.ev & in.wb;
    t.er   = t.ev & in.r;
    t.ew   = t.ev & in.w;
    t.ealu = in.alu;
    t.erm  = in.rm;
    t.ed   = in.d;
    t.efz  = 1'b0;
    t.esc  = 16'h0;
    t.cd   = t.ev;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    validIn = t.v; flushIn = t.f; WB_ENIn = t.wb; MEM_R_ENIn = t.r; MEM_W_ENIn = t.w;
    ALU_ResIn = t.alu; Value_RmIn = t.rm; DestIn = t.d;
  endtask

  task automatic drive_random();
    validIn = 1'($urandom); flushIn = 1'($urandom); WB_ENIn = 1'($urandom);
    MEM_R_ENIn = 1'($urandom); MEM_W_ENIn = 1'($urandom);
    ALU_ResIn = $urandom; Value_RmIn = $urandom; DestIn = 4'($urandom);
  endtask

  task automatic cmp_main(input vec_t e, input string tag);
    check({tag, " validOut"},    32'(m_v),  32'(e.ev));
    check({tag, " WB_ENOut"},    32'(m_wb), 32'(e.ewb));
    check({tag, " MEM_R_ENOut"}, 32'(m_r),  32'(e.er));
    check({tag, " MEM_W_ENOut"}, 32'(m_w),  32'(e.ew));
    check({tag, " freezeOut"},   32'(m_fz), 32'(e.efz));
    check({tag, " stallCntOut"}, 32'(m_sc), 32'(e.esc));
    if (e.cd) begin
      check({tag, " ALU_ResOut"},  m_alu,      e.ealu);
      check({tag, " Value_RmOut"}, m_rm,       e.erm);
      check({tag, " DestOut"},     32'(m_d),   32'(e.ed));
    end
  endtask

  task automatic cmp_z0(input vec_t e, input string tag);
    check({tag, " z0 validOut"},    32'(z_v),  32'(e.ev));
    check({tag, " z0 WB_ENOut"},    32'(z_wb), 32'(e.ewb));
    check({tag, " z0 MEM_R_ENOut"}, 32'(z_r),  32'(e.er));
    check({tag, " z0 MEM_W_ENOut"}, 32'(z_w),  32'(e.ew));
    check({tag, " z0 freezeOut"},   32'(z_fz), 32'(e.efz));
    check({tag, " z0 stallCntOut"}, 32'(z_sc), 32'(e.esc));
    if (e.cd) begin
      check({tag, " z0 ALU_ResOut"}, z_alu,    e.ealu);
      check({tag, " z0 DestOut"},    32'(z_d), 32'(e.ed));
    end
  endtask

  task automatic check_all_zero(input string tag);
    vec_t zero;
    zero = mk(0,0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0, 0,16'h0,1);
    cmp_main(zero, tag);
    cmp_z0(zero, tag);
    check({tag, " sat freezeOut"},   32'(s_fz), 32'h0);
    check({tag, " sat stallCntOut"}, 32'(s_sc), 32'h0);
  endtask

  initial begin
    vec_t e;
    int   exp_sc;

    // ALU op, load with following ALU op, back-to-back stores, bubbles, flushes, R+W.
    vecs[0]  = mk(1,0,1,0,0, 32'h10, 32'h0, 4'd5,   1,1,0,0, 32'h10,  32'h0,  4'd5, 0, 16'd0,  1);
    vecs[1]  = mk(1,0,1,1,0, 32'h400,32'h0, 4'd3,   1,0,1,0, 32'h400, 32'h0,  4'd3, 1, 16'd0,  1);
    vecs[2]  = mk(1,0,1,0,0, 32'h20, 32'h0, 4'd7,   1,0,1,0, 32'h400, 32'h0,  4'd3, 1, 16'd1,  1);
    vecs[3]  = mk(1,0,1,0,0, 32'h20, 32'h0, 4'd7,   1,1,1,0, 32'h400, 32'h0,  4'd3, 0, 16'd2,  1);
    vecs[4]  = mk(1,0,1,0,0, 32'h20, 32'h0, 4'd7,   1,1,0,0, 32'h20,  32'h0,  4'd7, 0, 16'd2,  1);
    vecs[5]  = mk(1,0,0,0,1, 32'h100,32'hA, 4'd0,   1,0,0,1, 32'h100, 32'hA,  4'd0, 1, 16'd2,  1);
    vecs[6]  = mk(1,0,0,0,1, 32'h104,32'hB, 4'd0,   1,0,0,1, 32'h100, 32'hA,  4'd0, 1, 16'd3,  1);
    vecs[7]  = mk(1,0,0,0,1, 32'h104,32'hB, 4'd0,   1,0,0,1, 32'h100, 32'hA,  4'd0, 0, 16'd4,  1);
    vecs[8]  = mk(1,0,0,0,1, 32'h104,32'hB, 4'd0,   1,0,0,1, 32'h104, 32'hB,  4'd0, 1, 16'd4,  1);
    vecs[9]  = mk(0,0,0,0,0, 32'h104,32'hB, 4'd0,   1,0,0,1, 32'h104, 32'hB,  4'd0, 1, 16'd5,  1);
    vecs[10] = mk(0,0,0,0,0, 32'h104,32'hB, 4'd0,   1,0,0,1, 32'h104, 32'hB,  4'd0, 0, 16'd6,  1);
    vecs[11] = mk(0,0,0,0,0, 32'h104,32'hB, 4'd0,   0,0,0,0, 32'h0,   32'h0,  4'd0, 0, 16'd6,  0);
    vecs[12] = mk(1,1,1,1,0, 32'h500,32'h0, 4'd4,   0,0,0,0, 32'h0,   32'h0,  4'd0, 0, 16'd6,  0);
    vecs[13] = mk(1,0,1,1,0, 32'h200,32'h0, 4'd9,   1,0,1,0, 32'h200, 32'h0,  4'd9, 1, 16'd6,  1);
    vecs[14] = mk(1,1,1,0,0, 32'h300,32'h0, 4'd1,   1,0,1,0, 32'h200, 32'h0,  4'd9, 1, 16'd7,  1);
    vecs[15] = mk(1,1,1,0,0, 32'h300,32'h0, 4'd1,   1,1,1,0, 32'h200, 32'h0,  4'd9, 0, 16'd8,  1);
    vecs[16] = mk(1,0,1,0,0, 32'h300,32'h0, 4'd1,   1,1,0,0, 32'h300, 32'h0,  4'd1, 0, 16'd8,  1);
    vecs[17] = mk(1,0,1,1,1, 32'h40, 32'h55,4'd2,   1,0,1,1, 32'h40,  32'h55, 4'd2, 1, 16'd8,  1);
    vecs[18] = mk(0,0,0,0,0, 32'h0,  32'h0, 4'd0,   1,0,1,1, 32'h40,  32'h55, 4'd2, 1, 16'd9,  1);
    vecs[19] = mk(0,0,0,0,0, 32'h0,  32'h0, 4'd0,   1,1,1,1, 32'h40,  32'h55, 4'd2, 0, 16'd10, 1);
    vecs[20] = mk(0,0,0,0,0, 32'h0,  32'h0, 4'd0,   0,0,0,0, 32'h0,   32'h0,  4'd0, 0, 16'd10, 0);

    rst = 1'b0;
    drive_random();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check_all_zero($sformatf("reset%0d", i));
      drive_random();
    end
    rst = 1'b1;

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i]);
      q_main.push_back(vecs[i]);
      q_z0.push_back(model_z0(vecs[i]));
      @(posedge clk); #1;
      e = q_main.pop_front();
      cmp_main(e, $sformatf("row%0d", i));
      e = q_z0.pop_front();
      cmp_z0(e, $sformatf("row%0d", i));
    end

    // Reset arriving while a load is in its last hold cycle.
    drive(mk(1,0,1,1,0, 32'h600,32'h0,4'd6, 0,0,0,0,0,0,0,0,16'h0,0));
    @(posedge clk); #1;
    check("midhold load freezeOut", 32'(m_fz), 32'h1);
    drive(mk(0,0,0,0,0, 32'h0,32'h0,4'd0, 0,0,0,0,0,0,0,0,16'h0,0));
    @(posedge clk); #1;
    check("midhold cnt1 freezeOut", 32'(m_fz), 32'h1);
    rst = 1'b0;
    drive_random();
    @(posedge clk); #1;
    check_all_zero("midhold reset");
    rst = 1'b1;

    // Continuous loads into the 8-bit counter instance until well past saturation.
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    drive(mk(1,0,1,1,0, 32'h800,32'h0,4'd8, 0,0,0,0,0,0,0,0,16'h0,0));
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); #1;
      exp_sc = k - (k + 3) / 4;
      if (exp_sc > 255) exp_sc = 255;
      check($sformatf("sat stallCnt k=%0d", k), 32'(s_sc), 32'(exp_sc));
    end
    check("sat final stallCnt", 32'(s_sc), 32'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exe_mem_reg.md
Name: exe_mem_reg

Overview:
- Pipeline register between the EXE stage and the MEM stage; it captures EXE results and control and drives the MEM stage inputs.
- Contains a wait-state sequencer for a multi-cycle data memory. It holds a load or store in the MEM stage for MEM_WAIT extra cycles and asserts freezeOut to stall IF/ID/EXE during that time.
- Write-back enable is exposed only in the final cycle of an access, so MEM/WB commits each instruction exactly once.

Parameters:
N, 32, datapath width
MEM_WAIT, 2, extra hold cycles per load/store (0 = plain register, no stalls)
STALL_W, 16, width of stall performance counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-low reset
validIn  input  1  EXE holds a real instruction
flushIn  input  1  squash instruction being captured this cycle
WB_ENIn  input  1  write-back enable from EXE
MEM_R_ENIn  input  1  load
MEM_W_ENIn  input  1  store
ALU_ResIn  input  N  ALU result / memory address
Value_RmIn  input  N  store data
DestIn  input  4  destination register
validOut  output  1  registered valid
WB_ENOut  output  1  gated write-back enable to MEM stage
MEM_R_ENOut  output  1  registered load enable
MEM_W_ENOut  output  1  registered store enable
ALU_ResOut  output  N  registered ALU result
Value_RmOut  output  N  registered store data
DestOut  output  4  registered destination
freezeOut  output  1  stall request to upstream stages
stallCntOut  output  STALL_W  saturating count of freeze cycles

Behaviour:
- Reset: on a rising edge with rst=0, every register clears: valid, enables, data, Dest, cnt, stallCnt. All outputs read 0 the following cycle, including freezeOut. Reset overrides all other inputs, including in the middle of a hold.
- Internal counter cnt has width clog2(MEM_WAIT+1), minimum 1. RUN state is cnt==0; HOLD state is cnt!=0.
- freezeOut = (cnt!=0), combinational from the register only, with no input-to-output path.
- RUN, each edge: capture all inputs.
  - Captured instruction is a bubble if flushIn=1 or validIn=0. A bubble clears valid, WB_EN, MEM_R_EN and MEM_W_EN; data and Dest fields are don't-care.
  - cnt <= MEM_WAIT if the captured instruction is valid and (MEM_R_ENIn | MEM_W_ENIn), else 0.
- HOLD, each edge: all payload registers hold and inputs are ignored, including flushIn, since upstream is frozen. cnt <= cnt-1.
- A memory op therefore occupies the register for MEM_WAIT+1 cycles. A non-memory op occupies it for 1 cycle.
- Output gating during HOLD:
  - WB_ENOut = WB_EN_q & (cnt==0).
  - MEM_R_ENOut and MEM_W_ENOut are unmasked during HOLD. Repeated writes of the same address and data are permitted.
- The next instruction is captured on the edge that ends the last hold cycle, with no bubble inserted.
- If MEM_R_ENIn and MEM_W_ENIn are both 1, both are passed through unchanged; one wait sequence is applied.
- stallCnt increments on each edge where freezeOut=1. It saturates at all-ones and does not wrap. It clears only on reset.
- With MEM_WAIT=0 the block is a flushable register: freezeOut stays 0 and WB_ENOut tracks WB_EN_q.

Test Plan:
1. Reset: drive rst=0 for 2 cycles with random inputs. Required response: all outputs 0, freezeOut=0, stallCntOut=0. Release rst=1.
2. ALU op, MEM_WAIT=2: validIn=1, WB_ENIn=1, DestIn=5, ALU_ResIn=0x10. Required response next cycle: WB_ENOut=1, DestOut=5, ALU_ResOut=0x10, freezeOut=0.
3. Load, MEM_WAIT=2: MEM_R_ENIn=1, WB_ENIn=1, ALU_ResIn=0x400, DestIn=3. Required response over 3 cycles after capture:
   - freezeOut = 1, 1, 0.
   - WB_ENOut = 0, 0, 1.
   - MEM_R_ENOut = 1 throughout.
   - Following ALU op appears on the 4th cycle.
   - stallCntOut=2.
4. Back-to-back stores (Value_RmIn=0xA, then 0xB), MEM_WAIT=2. Required response: freezeOut = 1,1,0,1,1,0; Value_RmOut held at 0xA for 3 cycles, then 0xB; WB_ENOut=0 throughout.
5. Flush: load presented with flushIn=1. Required response next cycle: validOut=0, all enables 0, freezeOut=0. Also, flushIn=1 asserted during HOLD has no effect.
6. Reset mid-hold: rst=0 while cnt=1. Required response next cycle: all outputs 0 and freezeOut=0. Separately, force 0xFFFF stall cycles (STALL_W=16) and check stallCntOut stays at 0xFFFF.
